sram_port_arbiter: RTL
======================

Name: sram_port_arbiter

Overview:
Shares the single external SRAM port between three requesters: the VGA display fetcher, the image decoder datapath, and the UART image loader. Each requester presents a one-cycle request with address and write data. The arbiter grants one requester per cycle and drives the registered SRAM address, write-data and write-enable signals. It returns read data to the granted reader through a tag pipeline that matches the SRAM read latency. Sits in the top level between the requester units and the SRAM controller.

Parameters:
READ_LATENCY, 3, cycles from grant cycle t to the cycle in which the matching read data is valid on SRAM_read_data (range 2..6)
ADDR_W, 18, SRAM address width
DATA_W, 16, SRAM data width

Ports:
Clock  input  1  system clock, rising edge
Resetn  input  1  asynchronous, active-low reset
arb_enable  input  1  when low, no new grants; in-flight reads still complete
vga_req  input  1  VGA read request (read-only requester)
vga_address  input  ADDR_W  VGA read address
vga_grant  output  1  combinational grant to VGA, cycle of request
vga_rd_valid  output  1  VGA read data valid on rd_data
dec_req  input  1  decoder request
dec_we_n  input  1  decoder write enable, active-low (1 = read)
dec_address  input  ADDR_W  decoder address
dec_write_data  input  DATA_W  decoder write data
dec_grant  output  1  combinational grant to decoder
dec_rd_valid  output  1  decoder read data valid
uart_req  input  1  UART request (writes only; uart_we_n tied 0 by user)
uart_we_n  input  1  UART write enable, active-low
uart_address  input  ADDR_W  UART address
uart_write_data  input  DATA_W  UART write data
uart_grant  output  1  combinational grant to UART
uart_rd_valid  output  1  UART read data valid
rd_data  output  DATA_W  SRAM_read_data passed through combinationally
SRAM_read_data  input  DATA_W  data from SRAM controller
SRAM_address  output  ADDR_W  registered SRAM address
SRAM_write_data  output  DATA_W  registered SRAM write data
SRAM_we_n  output  1  registered SRAM write enable, active-low
conflict_count  output  16  saturating count of cycles with two or more simultaneous requests

Behaviour:
- Reset values: SRAM_address 0, SRAM_write_data 0, SRAM_we_n 1, all grants and rd_valids 0, conflict_count 0, round-robin pointer set to decoder, tag pipeline cleared.
- Grants are combinational and one-hot or zero. The grant vector is all zero when arb_enable=0.
- Priority: VGA is absolute. VGA is never delayed or preempted, because its fetch pattern is timed to pixel position.
- Decoder vs UART, when neither is blocked by VGA: round-robin. The pointer names the preferred requester. The pointer toggles only when the preferred requester is granted while the other one is also requesting. Lone requests are granted without moving the pointer.
- A requester that is not granted must hold req, address and data stable until it sees its grant. The arbiter keeps no request queue.
- Grant in cycle t: at the end of t, SRAM_address, SRAM_write_data and SRAM_we_n register the winner's values. The port is driven during t+1.
- No grant in cycle t: SRAM_we_n registers 1, and SRAM_address and SRAM_write_data hold their previous values.
- Tag pipeline: READ_LATENCY-1 registers, each holding {valid, 2-bit requester id}.
  - A granted read (we_n=1) inserts a valid tag; a granted write or an idle cycle inserts an invalid tag.
  - <req>_rd_valid is high in cycle t+READ_LATENCY exactly when the tag at the pipeline output is valid and its id matches <req>.
  - rd_data = SRAM_read_data at all times.
- Back-to-back grants to different requesters are legal every cycle; returns occur in grant order with no bubbles.
- arb_enable falling mid-stream: no new grants from the next combinational evaluation. Already-issued tags still produce rd_valid pulses.
- conflict_count: increments when two or more of the three req inputs are high in a cycle, independent of arb_enable; saturates at 16'hFFFF.
- Reset asserted mid-operation: all tags are discarded immediately and no rd_valid pulse follows the deassertion of reset.
- A request that is not granted produces no SRAM activity and no rd_valid.

Test Plan:
- Reset, then all reqs 0 for 10 cycles -> SRAM_we_n=1, SRAM_address=0, no grants, conflict_count=0.
- VGA read at address 0x00010 alone in cycle t -> vga_grant=1 in t; SRAM_address=0x00010 in t+1; vga_rd_valid=1 only in t+3 with rd_data equal to the model's data.
- VGA, decoder and UART all request for 6 cycles; decoder and UART hold their requests -> VGA granted all 6 cycles; decoder and UART are then granted alternately, decoder first; conflict_count=6 plus the cycles in which decoder and UART overlap.
- Decoder write (we_n=0, address 0x1F000, data 0xBEEF) interleaved with VGA reads in alternate cycles -> SRAM_we_n=0 for exactly one cycle with the correct address and data; no dec_rd_valid; VGA return timing unchanged.
- Three reads granted in consecutive cycles (VGA, decoder, VGA), then arb_enable=0 -> rd_valid pulses VGA, decoder, VGA in consecutive cycles t+3..t+5; no further grants.
- Resetn pulsed low one cycle after a decoder read grant -> no dec_rd_valid ever asserted; outputs return to reset values asynchronously.

Source files
------------

// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if
//   Bundles the requester-side handshakes and the SRAM controller port of
//   sram_port_arbiter.
//   slave  : arbiter view (requests in, grants/returns/SRAM drive out)
//   master : requester + SRAM controller view (the opposite directions)
//   Signals: arb_enable; vga_*/dec_*/uart_* request, grant and rd_valid;
//            rd_data; SRAM_read_data, SRAM_address, SRAM_write_data,
//            SRAM_we_n; conflict_count.
interface sram_port_arbiter_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
);
    logic              arb_enable;

    logic              vga_req;
    logic [ADDR_W-1:0] vga_address;
    logic              vga_grant;
    logic              vga_rd_valid;

    logic              dec_req;
    logic              dec_we_n;
    logic [ADDR_W-1:0] dec_address;
    logic [DATA_W-1:0] dec_write_data;
    logic              dec_grant;
    logic              dec_rd_valid;

    logic              uart_req;
    logic              uart_we_n;
    logic [ADDR_W-1:0] uart_address;
    logic [DATA_W-1:0] uart_write_data;
    logic              uart_grant;
    logic              uart_rd_valid;

    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] SRAM_read_data;
    logic [ADDR_W-1:0] SRAM_address;
    logic [DATA_W-1:0] SRAM_write_data;
    logic              SRAM_we_n;
    logic [15:0]       conflict_count;

    modport slave (
        input  arb_enable,
        input  vga_req, vga_address,
        output vga_grant, vga_rd_valid,
        input  dec_req, dec_we_n, dec_address, dec_write_data,
        output dec_grant, dec_rd_valid,
        input  uart_req, uart_we_n, uart_address, uart_write_data,
        output uart_grant, uart_rd_valid,
        output rd_data,
        input  SRAM_read_data,
        output SRAM_address, SRAM_write_data, SRAM_we_n,
        output conflict_count
    );

    modport master (
        output arb_enable,
        output vga_req, vga_address,
        input  vga_grant, vga_rd_valid,
        output dec_req, dec_we_n, dec_address, dec_write_data,
        input  dec_grant, dec_rd_valid,
        output uart_req, uart_we_n, uart_address, uart_write_data,
        input  uart_grant, uart_rd_valid,
        input  rd_data,
        output SRAM_read_data,
        input  SRAM_address, SRAM_write_data, SRAM_we_n,
        input  conflict_count
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares one SRAM port between the VGA fetcher (read-only, absolute
//   priority), the image decoder and the UART loader (round-robin between
//   the two). One grant per cycle; the winner's address/data/we_n are
//   registered onto the SRAM port, and a tag pipeline steers the returning
//   read data to the requester that issued the read.
//   Ports:
//     Clock, Resetn : clock (rising edge), asynchronous active-low reset
//     bus           : sram_port_arbiter_if.slave (requests, grants,
//                     rd_valid strobes, rd_data, SRAM port, conflict_count)
module sram_port_arbiter #(
    parameter int READ_LATENCY = 3,
    parameter int ADDR_W       = 18,
    parameter int DATA_W       = 16
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    sram_port_arbiter_if.slave   bus
);
    localparam int TAG_STAGES = READ_LATENCY - 1;

    localparam logic [1:0] ID_VGA  = 2'd0;
    localparam logic [1:0] ID_DEC  = 2'd1;
    localparam logic [1:0] ID_UART = 2'd2;

    typedef struct packed {
        logic       vld;
        logic [1:0] id;
    } tag_t;

    // Round-robin pointer: 0 = decoder preferred, 1 = UART preferred.
    logic ptr_uart, ptr_uart_nxt;

    logic              grant_vga, grant_dec, grant_uart;
    logic              any_grant;
    logic [ADDR_W-1:0] win_address;
    logic [DATA_W-1:0] win_data;
    logic              win_we_n;
    logic [1:0]        win_id;

    logic [ADDR_W-1:0] sram_address_q;
    logic [DATA_W-1:0] sram_write_data_q;
    logic              sram_we_n_q;

    // Tag for the access currently on the SRAM port (cycle t+1), followed by
    // TAG_STAGES more registers so the tag surfaces in cycle t+READ_LATENCY.
    tag_t                  issue_tag;
    tag_t [TAG_STAGES-1:0] tag_pipe;
    tag_t                  tag_out;

    logic [15:0] conflict_q;
    logic        multi_req;

    // ---------------- grant logic ----------------
    always_comb begin
        grant_vga    = 1'b0;
        grant_dec    = 1'b0;
        grant_uart   = 1'b0;
        ptr_uart_nxt = ptr_uart;
        if (Resetn && bus.arb_enable) begin
            if (bus.vga_req) begin
                grant_vga = 1'b1;
            end else if (bus.dec_req && bus.uart_req) begin
                // Contended: serve the preferred side, then hand preference over.
                if (ptr_uart) grant_uart = 1'b1;
                else          grant_dec  = 1'b1;
                ptr_uart_nxt = ~ptr_uart;
            end else if (bus.dec_req) begin
                grant_dec = 1'b1;
            end else if (bus.uart_req) begin
                grant_uart = 1'b1;
            end
        end
    end

    // ---------------- winner mux ----------------
    always_comb begin
        any_grant   = grant_vga | grant_dec | grant_uart;
        win_address = sram_address_q;
        win_data    = sram_write_data_q;
        win_we_n    = 1'b1;
        win_id      = ID_VGA;
        if (grant_vga) begin
            win_address = bus.vga_address;
            win_we_n    = 1'b1;
            win_id      = ID_VGA;
        end else if (grant_dec) begin
            win_address = bus.dec_address;
            win_data    = bus.dec_write_data;
            win_we_n    = bus.dec_we_n;
            win_id      = ID_DEC;
        end else if (grant_uart) begin
            win_address = bus.uart_address;
            win_data    = bus.uart_write_data;
            win_we_n    = bus.uart_we_n;
            win_id      = ID_UART;
        end
    end

    // ---------------- SRAM port registers + pointer ----------------
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            sram_address_q    <= '0;
            sram_write_data_q <= '0;
            sram_we_n_q       <= 1'b1;
            ptr_uart          <= 1'b0;
        end else begin
            // Idle cycles keep address/data; only we_n returns to 1.
            sram_address_q    <= win_address;
            sram_write_data_q <= win_data;
            sram_we_n_q       <= win_we_n;
            ptr_uart          <= ptr_uart_nxt;
        end
    end

    // ---------------- tag pipeline ----------------
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            issue_tag <= '0;
            tag_pipe  <= '0;
        end else begin
            issue_tag.vld <= any_grant & win_we_n;
            issue_tag.id  <= win_id;
            tag_pipe[0]   <= issue_tag;
            for (int i = 1; i < TAG_STAGES; i++)
                tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    assign tag_out = tag_pipe[TAG_STAGES-1];

    // ---------------- conflict counter ----------------
    assign multi_req = (bus.vga_req & bus.dec_req) |
                       (bus.vga_req & bus.uart_req) |
                       (bus.dec_req & bus.uart_req);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn)
            conflict_q <= '0;
        else if (multi_req && conflict_q != 16'hFFFF)
            conflict_q <= conflict_q + 16'd1;
    end

    // ---------------- outputs ----------------
    assign bus.vga_grant       = grant_vga;
    assign bus.dec_grant       = grant_dec;
    assign bus.uart_grant      = grant_uart;
    assign bus.vga_rd_valid    = tag_out.vld && tag_out.id == ID_VGA;
    assign bus.dec_rd_valid    = tag_out.vld && tag_out.id == ID_DEC;
    assign bus.uart_rd_valid   = tag_out.vld && tag_out.id == ID_UART;
    assign bus.rd_data         = bus.SRAM_read_data;
    assign bus.SRAM_address    = sram_address_q;
    assign bus.SRAM_write_data = sram_write_data_q;
    assign bus.SRAM_we_n       = sram_we_n_q;
    assign bus.conflict_count  = conflict_q;
endmodule
